fifo_rd_stream: RTL and testbench



---
 rtl/fifo_rd_pkg.sv | 13 +
 rtl/fifo_rd_skid.sv | 66 ++++++
 rtl/fifo_rd_stream.sv | 100 ++++++++++
 tb/tb_fifo_rd_stream.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and sizing for the async-FIFO read-side drain engine.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fifo_rd_pkg;

  localparam int SKID_DEPTH = 3;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// In-order 3-entry skid buffer with registered head data and valid.
// Latency: a pushed word is visible at the head the cycle after the push edge.
// Backpressure: caller must never push into a full buffer without a same-cycle pop.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             push,
  input  logic [DSIZE-1:0] push_dat,
  input  logic             pop,
  input  logic             clear,
  output logic [1:0]       occ,
  output logic [DSIZE-1:0] head_dat,
  output logic             head_vld
);

  logic [DSIZE-1:0] mem_q   [SKID_DEPTH];
  logic [DSIZE-1:0] mem_nxt [SKID_DEPTH];
  logic [1:0]       occ_q;
  logic [1:0]       occ_nxt;
  logic [1:0]       wr_idx;
  logic             vld_q;

  // Shift toward the head on pop, then drop the pushed word into the first free slot.
  always_comb begin
    occ_nxt    = occ_q + {1'b0, push} - {1'b0, pop};
    wr_idx     = pop ? (occ_q - 2'd1) : occ_q;
    mem_nxt[0] = pop ? mem_q[1] : mem_q[0];
    mem_nxt[1] = pop ? mem_q[2] : mem_q[1];
    mem_nxt[2] = mem_q[2];
    if (push) begin
      case (wr_idx)
        2'd0:    mem_nxt[0] = push_dat;
        2'd1:    mem_nxt[1] = push_dat;
        2'd2:    mem_nxt[2] = push_dat;
        default: ;
      endcase
    end
  end

  // Storage, occupancy and head-valid registers; clear wins over push.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      occ_q <= 2'd0;
      vld_q <= 1'b0;
    end else if (clear) begin
      occ_q <= 2'd0;
      vld_q <= 1'b0;
    end else begin
      mem_q <= mem_nxt;
      occ_q <= occ_nxt;
      vld_q <= (occ_nxt != 2'd0);
    end
  end

  assign occ      = occ_q;
  assign head_dat = mem_q[0];
  assign head_vld = vld_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains the async FIFO read port into a valid/ready stream, with flush and word count.
// Latency: 2 rclk cycles from rinc to m_valid; one word per cycle sustained.
// Backpressure: reads stop once buffered plus in-flight words reach 3; m_ready never reaches rinc.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DSIZE  = 8,
  parameter int CWIDTH = 16
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic              rempty,
  input  logic [DSIZE-1:0]  rdata,
  output logic              rinc,
  output logic [DSIZE-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  input  logic              flush,
  output logic              flushing,
  output logic [CWIDTH-1:0] rd_count
);

  rd_state_e         state_q;
  rd_state_e         state_nxt;
  logic              pend_q;
  logic [CWIDTH-1:0] cnt_q;
  logic [1:0]        occ;
  logic [2:0]        inflight;
  logic              push;
  logic              pop;
  logic              clear;

  assign inflight = {1'b0, occ} + {2'b00, pend_q};
  assign pop      = m_valid && m_ready;

  fifo_rd_skid #(
    .DSIZE (DSIZE)
  ) u_skid (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .push     (push),
    .push_dat (rdata),
    .pop      (pop),
    .clear    (clear),
    .occ      (occ),
    .head_dat (m_data),
    .head_vld (m_valid)
  );

  // FSM state register.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state_q <= RUN;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Enter FLUSH on a flush pulse; leave once no read is left in flight.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      RUN:     if (flush) state_nxt = FLUSH;
      FLUSH:   if (!pend_q) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // Issue, capture and clear strobes; a word landing during a flush is dropped.
  always_comb begin
    rinc  = 1'b0;
    push  = 1'b0;
    clear = 1'b0;
    case (state_q)
      RUN: begin
        rinc  = rrst_n && !rempty && (inflight < 3'(SKID_DEPTH));
        push  = pend_q && !flush;
        clear = flush;
      end
      default: ;
    endcase
  end

  // Track the read in flight and count completed handshakes.
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      pend_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      pend_q <= rinc;
      if (pop) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign flushing = (state_q == FLUSH);
  assign rd_count = cnt_q;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream driving a behavioural FIFO read port.
// Latency: inputs driven 1 time unit after rclk rise, outputs sampled on rclk fall.
// Backpressure: m_ready is steered per scenario (held, dropped, toggled).
module tb_fifo_rd_stream;

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b0;
  logic       rempty = 1'b1;
  logic [7:0] rdata = 8'h00;
  logic       rinc;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready = 1'b0;
  logic       flush = 1'b0;
  logic       flushing;
  logic [3:0] rd_count;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  logic [7:0] fq[$];
  logic [7:0] got_q[$];
  int         got_cyc[$];
  int         rd_cyc[$];
  logic       rd_req = 1'b0;

  fifo_rd_stream #(
    .DSIZE  (8),
    .CWIDTH (4)
  ) dut (
    .rclk     (rclk),
    .rrst_n   (rrst_n),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .flush    (flush),
    .flushing (flushing),
    .rd_count (rd_count)
  );

  initial forever #5 rclk = ~rclk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // Monitor: record reads and handshakes away from the active edge.
  always @(negedge rclk) begin
    cyc++;
    rd_req <= rinc && !rempty;
    if (rinc && !rempty) rd_cyc.push_back(cyc);
    if (m_valid && m_ready) begin
      got_q.push_back(m_data);
      got_cyc.push_back(cyc);
    end
  end

  // FIFO read port model: registered rdata and rempty.
  always @(posedge rclk) begin
    if (!rrst_n) begin
      fq.delete();
      rempty <= 1'b1;
      rdata  <= 8'h00;
    end else begin
      if (rd_req) rdata <= fq.pop_front();
      rempty <= (fq.size() == 0);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_logs();
    got_q.delete();
    got_cyc.delete();
    rd_cyc.delete();
  endtask

  task automatic write_words(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(base + 8'(i));
  endtask

  task automatic wait_got(input string tag, input int n);
    for (int i = 0; i < 300 && got_q.size() < n; i++) tick();
    chk(tag, got_q.size(), n);
  endtask

  task automatic check_seq(input string tag, input logic [7:0] base, input int n);
    for (int i = 0; i < n && i < got_q.size(); i++) chk(tag, got_q[i], base + 8'(i));
  endtask

  task automatic wait_valid(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge rclk);
      if (m_valid) begin
        found = 1'b1;
        break;
      end
    end
    chk(tag, found, 1'b1);
  endtask

  initial begin
    // Reset state
    idle(2);
    @(negedge rclk);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_data", m_data, 8'h00);
    chk("rst_count", rd_count, 4'd0);
    chk("rst_flushing", flushing, 1'b0);
    chk("rst_rinc", rinc, 1'b0);
    tick();
    rrst_n = 1'b1;
    idle(2);

    // Four words, downstream always ready
    clear_logs();
    m_ready = 1'b1;
    write_words(8'h11, 4);
    wait_got("t1_num", 4);
    check_seq("t1_data", 8'h11, 4);
    if (got_cyc.size() == 4 && rd_cyc.size() > 0) begin
      chk("t1_latency", got_cyc[0] - rd_cyc[0], 2);
      chk("t1_b2b", got_cyc[3] - got_cyc[0], 3);
    end
    chk("t1_count", rd_count, 4'd4);
    idle(3);

    // Eight words under backpressure, then release
    clear_logs();
    m_ready = 1'b0;
    write_words(8'h80, 8);
    idle(10);
    @(negedge rclk);
    chk("t2_reads", rd_cyc.size(), 3);
    chk("t2_valid", m_valid, 1'b1);
    chk("t2_hold0", m_data, 8'h80);
    tick();
    @(negedge rclk);
    chk("t2_hold1", m_data, 8'h80);
    chk("t2_rinc", rinc, 1'b0);
    tick();
    m_ready = 1'b1;
    wait_got("t2_num", 8);
    check_seq("t2_data", 8'h80, 8);
    if (got_cyc.size() == 8) chk("t2_b2b", got_cyc[7] - got_cyc[0], 7);
    chk("t2_count", rd_count, 4'd12);
    idle(3);

    // Sixteen words with m_ready toggling every cycle
    clear_logs();
    m_ready = 1'b0;
    write_words(8'h00, 16);
    for (int i = 0; i < 200 && got_q.size() < 16; i++) begin
      m_ready = ~m_ready;
      tick();
    end
    chk("t3_num", got_q.size(), 16);
    check_seq("t3_data", 8'h00, 16);
    m_ready = 1'b0;
    idle(5);
    chk("t3_extra", got_q.size(), 16);
    chk("t3_count", rd_count, 4'd12);

    // Flush with two buffered words and one in flight
    clear_logs();
    write_words(8'h51, 3);
    wait_valid("t4_fill");
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge rclk);
    chk("t4_valid", m_valid, 1'b0);
    chk("t4_flushing", flushing, 1'b1);
    chk("t4_rinc", rinc, 1'b0);
    tick();
    @(negedge rclk);
    chk("t4_flush_done", flushing, 1'b0);
    chk("t4_count_kept", rd_count, 4'd12);
    tick();
    write_words(8'hA5, 1);
    m_ready = 1'b1;
    idle(10);
    chk("t4_num", got_q.size(), 1);
    check_seq("t4_data", 8'hA5, 1);
    chk("t4_count", rd_count, 4'd13);
    m_ready = 1'b0;
    idle(3);

    // Reset mid-stream with two buffered words
    clear_logs();
    write_words(8'hC0, 5);
    wait_valid("t5_fill");
    tick();
    rrst_n = 1'b0;
    tick();
    @(negedge rclk);
    chk("t5_valid", m_valid, 1'b0);
    chk("t5_count", rd_count, 4'd0);
    chk("t5_rinc", rinc, 1'b0);
    tick();
    rrst_n = 1'b1;
    idle(2);

    // Refill after reset; 17 words wrap the 4-bit counter
    clear_logs();
    m_ready = 1'b1;
    write_words(8'h30, 17);
    wait_got("t6_num", 17);
    check_seq("t6_data", 8'h30, 17);
    chk("t6_count", rd_count, 4'd1);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
